unary_add_n_w: RTL and testbench
================================

// Module: unary_add_n_w
// PURPOSE
//  Parametrised unary-stream accumulator: the next generation of the 2-input, 3-bit unary adder.
//  Read phase: counts '1' bits on N_IN unary input lanes per cycle into a CNT_W-bit counter,
//  with selectable wrap or saturate on overflow. Write phase: replays the total as a unary
//  pulse train on dout, one pulse per cycle, with end-of-train and sticky-overflow flags.
// PARAMETERS
//  N_IN      2  number of unary input lanes (>=1)
//  CNT_W     3  accumulator width; MAX = 2**CNT_W-1
//  SATURATE  0  0: count wraps modulo 2**CNT_W on overflow; 1: count clamps at MAX
// PORTS
//  clk            in   1       clock, all state on rising edge
//  rst_n          in   1       synchronous active-low reset
//  en             in   1       cycle enable; 0 = hold state
//  read_or_write  in   1       0 = read (accumulate) phase, 1 = write (replay) phase
//  din            in   N_IN    unary input lanes, sampled in read phase only
//  dout           out  1       registered unary output pulse
//  C              out  1       registered per-cycle overflow/carry flag
//  ovf            out  1       sticky overflow flag
//  done           out  1       1-cycle pulse, coincident with the last dout pulse of a train
//  cnt_out        out  CNT_W   current count register
//  empty          out  1       combinational: cnt_out == 0
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge, overrides en): count=0, dout=0, C=0, ovf=0, done=0.
//   Synchronous only: a low rst_n pulse between edges has no effect.
//  en=0: count, dout, C, ovf hold; done forced 0 (never stretched).
//  Read (en=1, rw=0):
//   pc = popcount(din), width clog2(N_IN+1); sum = count + pc, computed 1 bit wider than max(CNT_W, pc width).
//   overflow = (sum > MAX). C <= overflow (re-evaluated every read cycle, not sticky).
//   SATURATE=0: count <= sum mod 2**CNT_W. SATURATE=1: count <= overflow ? MAX : sum.
//   ovf <= ovf | overflow. dout <= 0, done <= 0. pc=0 leaves count unchanged, C <= 0.
//  Write (en=1, rw=1): C <= 0.
//   count != 0: dout <= 1, count <= count-1, done <= (count == 1); ovf <= (count == 1) ? 0 : ovf.
//   count == 0: dout <= 0, done <= 0; count stays 0 (no underflow).
//  Latency: one cycle from sampled input/phase to registered outputs; an N-count train gives
//   exactly N consecutive dout=1 cycles while en=1, with done on the Nth.
//  Phase switch mid-train: remaining count is kept; a later read adds to the remainder; a
//   later write resumes the train. Switching write->read zeroes dout on the next edge.
//  Simultaneous: rst_n=0 beats en and rw; ovf set and cleared in the same cycle is impossible
//   (set only in read, cleared only in write).
// TESTING
//  T1 reset: mid-train with count=4, rst_n=0 for 1 edge -> count=0, dout=C=ovf=done=0 next cycle.
//  T2 wrap (N_IN=2,CNT_W=3): din=11 x3, then 01 -> count 7, C=0; then din=01 -> count 0, C=1, ovf=1.
//  T3 saturate (SATURATE=1): same stimulus as T2 -> count stays 7, C=1, ovf=1; din=11 at 6 -> 7, C=1.
//  T4 replay: count=5, rw=1 -> dout=1 for 5 cycles, done=1 only on 5th, then empty=1, dout=0.
//  T5 hold: during T4 drop en for 3 cycles after 2 pulses -> count=3 and dout held, done=0;
//      re-enable -> 3 more pulses, done on last, ovf cleared there.
//  T6 wide (N_IN=4,CNT_W=4): count=13, din=1111 -> count=1, C=1; then din=0000 -> count 1, C=0.

Source files
------------

// File: rtl/unary_add_n_w.sv
// -----------------------------------------------------------------------------
// unary_add_n_w
//
// Purpose:
//   Parametrised unary-stream accumulator. In the read phase it counts the
//   '1' lanes of din every enabled cycle into a CNT_W-bit counter. On overflow
//   the counter either wraps or clamps at MAX. In the write phase it replays
//   the stored total as a unary pulse train on dout, one pulse per enabled
//   cycle. done marks the last pulse. ovf is a sticky overflow flag that is
//   cleared when a train completes.
//
// Parameters:
//   N_IN      number of unary input lanes (>= 1)
//   CNT_W     accumulator width, MAX = 2**CNT_W - 1
//   SATURATE  0: wrap modulo 2**CNT_W, 1: clamp at MAX
//
// Ports:
//   clk            in   1      rising-edge clock for all state
//   rst_n          in   1      synchronous active-low reset, overrides en
//   en             in   1      cycle enable, 0 holds state (done forced 0)
//   read_or_write  in   1      0 = accumulate din, 1 = replay count on dout
//   din            in   N_IN   unary input lanes, sampled in read phase only
//   dout           out  1      registered unary output pulse
//   C              out  1      registered per-cycle overflow flag (not sticky)
//   ovf            out  1      sticky overflow, cleared at end of a train
//   done           out  1      one-cycle pulse on the last dout pulse
//   cnt_out        out  CNT_W  current count register
//   empty          out  1      combinational, cnt_out == 0
// -----------------------------------------------------------------------------
module unary_add_n_w #(
  parameter int N_IN     = 2,
  parameter int CNT_W    = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             read_or_write,
  input  logic [N_IN-1:0]  din,
  output logic             dout,
  output logic             C,
  output logic             ovf,
  output logic             done,
  output logic [CNT_W-1:0] cnt_out,
  output logic             empty
);

  // Width of the lane popcount: values 0..N_IN.
  localparam int PC_W  = $clog2(N_IN + 1);
  // The sum is one bit wider than the wider operand, so the carry is never lost.
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

  localparam logic [SUM_W-1:0] MAX_S   = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};
  localparam logic [CNT_W-1:0] MAX_C   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C  = '0;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] count_q, count_d;
  logic             dout_q,  dout_d;
  logic             c_q,     c_d;
  logic             ovf_q,   ovf_d;
  logic             done_q,  done_d;

  // ---------------------------------------------------------------------------
  // Read-phase datapath: popcount and widened sum
  // ---------------------------------------------------------------------------
  logic [PC_W-1:0]  pc;
  logic [SUM_W-1:0] sum;
  logic             overflow;

  always_comb begin
    pc = '0;
    for (int i = 0; i < N_IN; i++) begin
      pc = pc + PC_W'(din[i]);
    end
  end

  assign sum      = SUM_W'(count_q) + SUM_W'(pc);
  assign overflow = (sum > MAX_S);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every next-state signal gets a hold default first. This means no
    // branch can leave one unassigned and infer a latch.
    count_d = count_q;
    dout_d  = dout_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;            // done is a pulse and is never stretched by en=0

    if (en) begin
      if (!read_or_write) begin
        // Accumulate. The output pulse train stops at once on a switch to read.
        dout_d = 1'b0;
        c_d    = overflow;
        ovf_d  = ovf_q | overflow;
        if (SATURATE && overflow) begin
          count_d = MAX_C;
        end else begin
          count_d = sum[CNT_W-1:0];  // truncation is the modulo-2**CNT_W wrap
        end
      end else begin
        // Replay. The count stops at zero instead of underflowing.
        c_d = 1'b0;
        if (count_q != ZERO_C) begin
          dout_d  = 1'b1;
          count_d = count_q - ONE_C;
          done_d  = (count_q == ONE_C);
          // A finished train clears the sticky overflow of its load.
          if (count_q == ONE_C) begin
            ovf_d = 1'b0;
          end
        end else begin
          dout_d = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: the reset is sampled only on the clock edge, so it sits inside the
  // clocked branch and not in the sensitivity list. A reset pulse between
  // edges has no effect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      dout_q  <= 1'b0;
      c_q     <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: use non-blocking assignments for all state. Every register then
      // samples the pre-edge values, whatever the statement order.
      count_q <= count_d;
      dout_q  <= dout_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cnt_out = count_q;
  assign dout    = dout_q;
  assign C       = c_q;
  assign ovf     = ovf_q;
  assign done    = done_q;
  assign empty   = (count_q == ZERO_C);

endmodule

// File: tb/tb_unary_add_n_w.sv
// -----------------------------------------------------------------------------
// tb_unary_add_n_w
//
// Drives three instances of unary_add_n_w:
//   u_a : N_IN=2, CNT_W=3, wrap
//   u_s : N_IN=2, CNT_W=3, saturate (shares all inputs with u_a)
//   u_w : N_IN=4, CNT_W=4, wrap     (own din lanes)
// Expected values are computed by hand from the behavioural description.
// -----------------------------------------------------------------------------
module tb_unary_add_n_w;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       rw;
  logic [1:0] din2;
  logic [3:0] din4;

  logic       a_dout, a_c, a_ovf, a_done, a_empty;
  logic [2:0] a_cnt;
  logic       s_dout, s_c, s_ovf, s_done, s_empty;
  logic [2:0] s_cnt;
  logic       w_dout, w_c, w_ovf, w_done, w_empty;
  logic [3:0] w_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  unary_add_n_w #(.N_IN(2), .CNT_W(3), .SATURATE(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .read_or_write(rw), .din(din2),
    .dout(a_dout), .C(a_c), .ovf(a_ovf), .done(a_done),
    .cnt_out(a_cnt), .empty(a_empty)
  );

  unary_add_n_w #(.N_IN(2), .CNT_W(3), .SATURATE(1'b1)) u_s (
    .clk(clk), .rst_n(rst_n), .en(en), .read_or_write(rw), .din(din2),
    .dout(s_dout), .C(s_c), .ovf(s_ovf), .done(s_done),
    .cnt_out(s_cnt), .empty(s_empty)
  );

  unary_add_n_w #(.N_IN(4), .CNT_W(4), .SATURATE(1'b0)) u_w (
    .clk(clk), .rst_n(rst_n), .en(en), .read_or_write(rw), .din(din4),
    .dout(w_dout), .C(w_c), .ovf(w_ovf), .done(w_done),
    .cnt_out(w_cnt), .empty(w_empty)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle: apply inputs, take the edge, then sample 1 ns later.
  task automatic cyc(input logic e, input logic r, input logic [1:0] d2, input logic [3:0] d4);
    en   = e;
    rw   = r;
    din2 = d2;
    din4 = d4;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1'b1, 1'b0, 2'b11, 4'hF);   // reset must beat en and a read with ones
    rst_n = 1'b1;
  endtask

  task automatic chk_a(input string tag, input int cnt, input bit d, input bit c,
                       input bit o, input bit dn);
    check({tag, " a.cnt"},   a_cnt,   cnt);
    check({tag, " a.dout"},  a_dout,  d);
    check({tag, " a.C"},     a_c,     c);
    check({tag, " a.ovf"},   a_ovf,   o);
    check({tag, " a.done"},  a_done,  dn);
    check({tag, " a.empty"}, a_empty, (cnt == 0));
  endtask

  typedef struct {
    logic       en;
    logic       rw;
    logic [1:0] din;
    int         a_cnt; bit a_dout; bit a_c; bit a_ovf; bit a_done;
    int         s_cnt; bit s_dout; bit s_c; bit s_ovf; bit s_done;
  } vec_t;

  vec_t vt[12];

  initial begin
    // T2 (wrap) and T3 (saturate) run side by side from a reset start.
    //           en    rw    din    | a: cnt dout C ovf done | s: cnt dout C ovf done
    vt[0]  = '{1'b1, 1'b0, 2'b11,   2, 0, 0, 0, 0,   2, 0, 0, 0, 0};
    vt[1]  = '{1'b1, 1'b0, 2'b11,   4, 0, 0, 0, 0,   4, 0, 0, 0, 0};
    vt[2]  = '{1'b1, 1'b0, 2'b11,   6, 0, 0, 0, 0,   6, 0, 0, 0, 0};
    vt[3]  = '{1'b1, 1'b0, 2'b01,   7, 0, 0, 0, 0,   7, 0, 0, 0, 0};
    vt[4]  = '{1'b1, 1'b0, 2'b01,   0, 0, 1, 1, 0,   7, 0, 1, 1, 0};
    vt[5]  = '{1'b1, 1'b0, 2'b00,   0, 0, 0, 1, 0,   7, 0, 0, 1, 0};
    vt[6]  = '{1'b1, 1'b1, 2'b00,   0, 0, 0, 1, 0,   6, 1, 0, 1, 0};
    vt[7]  = '{1'b1, 1'b0, 2'b11,   2, 0, 0, 1, 0,   7, 0, 1, 1, 0};
    vt[8]  = '{1'b0, 1'b0, 2'b11,   2, 0, 0, 1, 0,   7, 0, 1, 1, 0};
    vt[9]  = '{1'b1, 1'b1, 2'b00,   1, 1, 0, 1, 0,   6, 1, 0, 1, 0};
    vt[10] = '{1'b1, 1'b1, 2'b00,   0, 1, 0, 0, 1,   5, 1, 0, 1, 0};
    vt[11] = '{1'b1, 1'b1, 2'b00,   0, 0, 0, 0, 0,   4, 1, 0, 1, 0};

    rst_n = 1'b1;
    en    = 1'b0;
    rw    = 1'b0;
    din2  = '0;
    din4  = '0;
    @(posedge clk);
    #1;

    // Reset state.
    do_reset();
    chk_a("rst0", 0, 0, 0, 0, 0);
    check("rst0 s.cnt", s_cnt, 0);
    check("rst0 w.cnt", w_cnt, 0);
    check("rst0 w.ovf", w_ovf, 0);

    // Table-driven: wrap and saturate.
    for (int i = 0; i < 12; i++) begin
      cyc(vt[i].en, vt[i].rw, vt[i].din, 4'h0);
      chk_a($sformatf("vec%0d", i), vt[i].a_cnt, vt[i].a_dout, vt[i].a_c,
            vt[i].a_ovf, vt[i].a_done);
      check($sformatf("vec%0d s.cnt", i),  s_cnt,  vt[i].s_cnt);
      check($sformatf("vec%0d s.dout", i), s_dout, vt[i].s_dout);
      check($sformatf("vec%0d s.C", i),    s_c,    vt[i].s_c);
      check($sformatf("vec%0d s.ovf", i),  s_ovf,  vt[i].s_ovf);
      check($sformatf("vec%0d s.done", i), s_done, vt[i].s_done);
    end

    // T1: reset in the middle of a train with count=4 and ovf set.
    do_reset();
    repeat (4) cyc(1'b1, 1'b0, 2'b11, 4'h0);   // 8 wraps to 0, ovf=1
    repeat (3) cyc(1'b1, 1'b0, 2'b11, 4'h0);   // 6
    cyc(1'b1, 1'b1, 2'b00, 4'h0);              // 5
    cyc(1'b1, 1'b1, 2'b00, 4'h0);              // 4, dout=1
    chk_a("t1 pre", 4, 1, 0, 1, 0);
    // A low pulse between edges must be ignored.
    en = 1'b0;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_a("t1 glitch", 4, 1, 0, 1, 0);
    rst_n = 1'b0;
    cyc(1'b1, 1'b1, 2'b00, 4'h0);
    rst_n = 1'b1;
    chk_a("t1 rst", 0, 0, 0, 0, 0);

    // T4/T5: 5-pulse train with a 3-cycle en=0 pause after 2 pulses.
    // ovf is preset by an overflowing load, so its clear at train end is visible.
    repeat (4) cyc(1'b1, 1'b0, 2'b11, 4'h0);   // 0, ovf=1
    cyc(1'b1, 1'b0, 2'b11, 4'h0);              // 2
    cyc(1'b1, 1'b0, 2'b11, 4'h0);              // 4
    cyc(1'b1, 1'b0, 2'b01, 4'h0);              // 5
    chk_a("t4 load", 5, 0, 0, 1, 0);
    cyc(1'b1, 1'b1, 2'b00, 4'h0);
    chk_a("t4 p1", 4, 1, 0, 1, 0);
    cyc(1'b1, 1'b1, 2'b00, 4'h0);
    chk_a("t4 p2", 3, 1, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 2'b11, 4'h0);
      chk_a($sformatf("t5 hold%0d", k), 3, 1, 0, 1, 0);
    end
    cyc(1'b1, 1'b1, 2'b00, 4'h0);
    chk_a("t5 p3", 2, 1, 0, 1, 0);
    cyc(1'b1, 1'b1, 2'b00, 4'h0);
    chk_a("t5 p4", 1, 1, 0, 1, 0);
    cyc(1'b1, 1'b1, 2'b00, 4'h0);
    chk_a("t5 p5", 0, 1, 0, 0, 1);
    cyc(1'b1, 1'b1, 2'b00, 4'h0);
    chk_a("t4 after", 0, 0, 0, 0, 0);

    // Phase switch mid-train: the remainder is kept and a read adds to it.
    cyc(1'b1, 1'b0, 2'b11, 4'h0);              // 2
    cyc(1'b1, 1'b1, 2'b00, 4'h0);              // 1, dout=1
    cyc(1'b1, 1'b0, 2'b01, 4'h0);              // 2, dout=0
    chk_a("sw read", 2, 0, 0, 0, 0);
    cyc(1'b1, 1'b1, 2'b00, 4'h0);
    chk_a("sw w1", 1, 1, 0, 0, 0);
    cyc(1'b1, 1'b1, 2'b00, 4'h0);
    chk_a("sw w2", 0, 1, 0, 0, 1);

    // T6: wide instance, 13 + 4 wraps to 1 with carry.
    do_reset();
    repeat (3) cyc(1'b1, 1'b0, 2'b00, 4'b1111); // 12
    cyc(1'b1, 1'b0, 2'b00, 4'b0001);            // 13
    check("t6 load cnt", w_cnt, 13);
    check("t6 load C",   w_c,   0);
    cyc(1'b1, 1'b0, 2'b00, 4'b1111);
    check("t6 wrap cnt", w_cnt, 1);
    check("t6 wrap C",   w_c,   1);
    check("t6 wrap ovf", w_ovf, 1);
    cyc(1'b1, 1'b0, 2'b00, 4'b0000);
    check("t6 zero cnt", w_cnt, 1);
    check("t6 zero C",   w_c,   0);
    check("t6 zero ovf", w_ovf, 1);
    cyc(1'b1, 1'b1, 2'b00, 4'b1111);            // din ignored in write
    check("t6 w cnt",   w_cnt,   0);
    check("t6 w dout",  w_dout,  1);
    check("t6 w done",  w_done,  1);
    check("t6 w ovf",   w_ovf,   0);
    check("t6 w empty", w_empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
